// File: rtl/onets_pkg.sv
// onets_pkg: shared PHY reset FSM encoding and interrupt counter limit
package onets_pkg;
  typedef enum logic [1:0] {ASSERT = 2'd0, SETTLE = 2'd1, READY = 2'd2} phy_rst_state_t;
  localparam logic [7:0] PHY_IRQ_CNT_MAX = 8'd255;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser with a configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) s_q <= {2{RST_VAL}};
    else s_q <= {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/phy_rst_seq.sv
// phy_rst_seq: timed PHY reset/ready sequencer plus PHY interrupt conditioner
// Interrupt path is built only when PHY_RST_IRQ_EN is defined.
module phy_rst_seq
  import onets_pkg::*;
#(
  parameter int RST_CYCLES    = 1_250_000,
  parameter int SETTLE_CYCLES = 625_000,
  parameter int CNT_W         = 21
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sw_rst_req,
  input  logic       phy_int_n,
  input  logic       irq_ack,
  output logic       phy_rstn,
  output logic       phy_ready,
  output logic       irq_pend,
  output logic [7:0] irq_cnt
);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  phy_rst_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phy_rstn_q, phy_ready_q;
  // outputs follow the state one cycle later, except a software request drops them at once
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= ASSERT;
      cnt_q       <= RST_LD;
      phy_rstn_q  <= 1'b0;
      phy_ready_q <= 1'b0;
    end else begin
      phy_rstn_q  <= !sw_rst_req && state_q != ASSERT;
      phy_ready_q <= !sw_rst_req && state_q == READY;
      if (sw_rst_req) begin
        state_q <= ASSERT;
        cnt_q   <= RST_LD;
      end else
        case (state_q)
          ASSERT:
            if (cnt_q == '0) begin
              state_q <= SETTLE;
              cnt_q   <= SET_LD;
            end else cnt_q <= cnt_q - 1'b1;
          SETTLE:
            if (cnt_q == '0) state_q <= READY;
            else cnt_q <= cnt_q - 1'b1;
          default: state_q <= READY;
        endcase
    end
  assign phy_rstn  = phy_rstn_q;
  assign phy_ready = phy_ready_q;
`ifdef PHY_RST_IRQ_EN
  logic       int_s, int_q, ev;
  logic       irq_pend_q;
  logic [7:0] irq_cnt_q;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rstn(rstn), .d_i(phy_int_n), .q_o(int_s));
  assign ev = int_q && !int_s && state_q == READY && !sw_rst_req;
  // an event beats a coincident ack so no interrupt is lost
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      int_q      <= 1'b1;
      irq_pend_q <= 1'b0;
      irq_cnt_q  <= 8'd0;
    end else begin
      int_q <= int_s;
      if (sw_rst_req) begin
        irq_pend_q <= 1'b0;
        irq_cnt_q  <= 8'd0;
      end else if (ev) begin
        irq_pend_q <= 1'b1;
        irq_cnt_q  <= irq_ack ? 8'd1 : (irq_cnt_q == PHY_IRQ_CNT_MAX ? irq_cnt_q : irq_cnt_q + 8'd1);
      end else if (irq_ack) begin
        irq_pend_q <= 1'b0;
        irq_cnt_q  <= 8'd0;
      end
    end
  assign irq_pend = irq_pend_q;
  assign irq_cnt  = irq_cnt_q;
`else
  logic unused_irq;
  assign unused_irq = phy_int_n ^ irq_ack;
  assign irq_pend   = 1'b0;
  assign irq_cnt    = 8'd0;
`endif
endmodule

// File: tb/tb_phy_rst_seq.sv
// tb_phy_rst_seq: directed + random bench for phy_rst_seq against an edge-count reference model
module tb_phy_rst_seq;
  localparam int RC = 16;
  localparam int SC = 8;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       phy_int_n = 1'b1;
  logic       irq_ack = 1'b0;
  logic       phy_rstn, phy_ready, irq_pend;
  logic [7:0] irq_cnt;
  int         n_cmp = 0;
  int         n_err = 0;

  phy_rst_seq #(.RST_CYCLES(RC), .SETTLE_CYCLES(SC), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .sw_rst_req(sw_rst_req), .phy_int_n(phy_int_n),
    .irq_ack(irq_ack), .phy_rstn(phy_rstn), .phy_ready(phy_ready),
    .irq_pend(irq_pend), .irq_cnt(irq_cnt)
  );

  always #5 clk = ~clk;

  // t = edges since the sequence last started; pin_h holds the last three sampled pin values
  int       t;
  logic [2:0] pin_h;
  logic     m_pend;
  int       m_cnt;
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      t <= 0;
      pin_h <= 3'b111;
      m_pend <= 1'b0;
      m_cnt <= 0;
    end else begin
      pin_h <= {pin_h[1:0], phy_int_n};
      if (sw_rst_req) begin
        t <= 0;
        m_pend <= 1'b0;
        m_cnt <= 0;
      end else begin
        if (t < 1000) t <= t + 1;
        if (pin_h[2] && !pin_h[1] && t >= RC + SC) begin
          m_pend <= 1'b1;
          m_cnt <= irq_ack ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        end else if (irq_ack) begin
          m_pend <= 1'b0;
          m_cnt <= 0;
        end
      end
    end

  function automatic logic [31:0] e_pend();
`ifdef PHY_RST_IRQ_EN
    return {31'd0, m_pend};
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] e_cnt();
`ifdef PHY_RST_IRQ_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic chk_all();
    chk("phy_rstn", {31'd0, phy_rstn}, {31'd0, t >= RC + 1});
    chk("phy_ready", {31'd0, phy_ready}, {31'd0, t >= RC + SC + 1});
    chk("irq_pend", {31'd0, irq_pend}, e_pend());
    chk("irq_cnt", {24'd0, irq_cnt}, e_cnt());
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_all();
    end
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    chk("rst_rstn", {31'd0, phy_rstn}, 32'd0);
    chk("rst_ready", {31'd0, phy_ready}, 32'd0);
    chk("rst_pend", {31'd0, irq_pend}, 32'd0);
    chk("rst_cnt", {24'd0, irq_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step(RC);
    chk("rstn_low_last", {31'd0, phy_rstn}, 32'd0);
    step(1);
    chk("rstn_high_first", {31'd0, phy_rstn}, 32'd1);
    step(SC - 1);
    chk("ready_low_last", {31'd0, phy_ready}, 32'd0);
    step(1);
    chk("ready_high_first", {31'd0, phy_ready}, 32'd1);
    step(5);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    chk("sw_ready_drop", {31'd0, phy_ready}, 32'd0);
    chk("sw_rstn_drop", {31'd0, phy_rstn}, 32'd0);
    step(4);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    step(RC);
    chk("sw2_rstn_low_last", {31'd0, phy_rstn}, 32'd0);
    step(1);
    chk("sw2_rstn_high", {31'd0, phy_rstn}, 32'd1);
    step(SC + 2);
    repeat (3) begin
      phy_int_n = 1'b0;
      step(4);
      phy_int_n = 1'b1;
      step(4);
    end
`ifdef PHY_RST_IRQ_EN
    chk("three_cnt", {24'd0, irq_cnt}, 32'd3);
    chk("three_pend", {31'd0, irq_pend}, 32'd1);
`endif
    repeat (300) begin
      phy_int_n = 1'b0;
      step(2);
      phy_int_n = 1'b1;
      step(2);
    end
    step(3);
`ifdef PHY_RST_IRQ_EN
    chk("sat_cnt", {24'd0, irq_cnt}, 32'd255);
`endif
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("ack_cnt", {24'd0, irq_cnt}, 32'd0);
    chk("ack_pend", {31'd0, irq_pend}, 32'd0);
    phy_int_n = 1'b0;
    step(2);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
`ifdef PHY_RST_IRQ_EN
    chk("coinc_pend", {31'd0, irq_pend}, 32'd1);
    chk("coinc_cnt", {24'd0, irq_cnt}, 32'd1);
`endif
    phy_int_n = 1'b1;
    step(4);
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) phy_int_n = ~phy_int_n;
      irq_ack = ($urandom_range(0, 15) == 0);
      sw_rst_req = ($urandom_range(0, 199) == 0);
      step(1);
    end
    irq_ack = 1'b0;
    sw_rst_req = 1'b0;
    phy_int_n = 1'b1;
    step(40);
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
    repeat (20) begin
      phy_int_n = ~phy_int_n;
      step(1);
    end
    chk("settle_no_evt", {24'd0, irq_cnt}, 32'd0);
    chk("settle_rstn", {31'd0, phy_rstn}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rstn", {31'd0, phy_rstn}, 32'd0);
    chk("async_ready", {31'd0, phy_ready}, 32'd0);
    chk("async_pend", {31'd0, irq_pend}, 32'd0);
    chk("async_cnt", {24'd0, irq_cnt}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phy_rst_seq.md
# phy_rst_seq

PHY reset sequencer and interrupt conditioner for the shared RGMII PHY reset line and the PHY interrupt pin. Sits between the PS-side control (clock and software reset request) and the board pins `rgmii_phy_rstn` / `rgmii_phy_int`. Produces a timed active-low PHY reset and a `phy_ready` qualifier for the MAC/MDIO logic. Converts the asynchronous PHY interrupt into a sticky, acknowledgeable request with a saturating event count.

## Interface
- `RST_CYCLES`, default 1_250_000: clock cycles `phy_rstn` is held low (10 ms at 125 MHz); must be ≥ 2.
- `SETTLE_CYCLES`, default 625_000: cycles from `phy_rstn` rising to `phy_ready` rising (5 ms); must be ≥ 1.
- `CNT_W`, default 21: width of the shared down-counter; must hold max(`RST_CYCLES`, `SETTLE_CYCLES`).

Ports:
- `clk` in 1: system clock (fclk0, 125 MHz).
- `rstn` in 1: asynchronous active-low reset.
- `sw_rst_req` in 1: single-cycle software request to re-run the PHY reset.
- `phy_int_n` in 1: raw PHY interrupt pin, active-low, asynchronous to `clk`.
- `irq_ack` in 1: single-cycle clear of `irq_pend`.
- `phy_rstn` out 1: registered PHY reset, active-low.
- `phy_ready` out 1: high when the PHY is out of reset and settled.
- `irq_pend` out 1: sticky PHY interrupt request.
- `irq_cnt` out 8: saturating count of interrupt events since the last `irq_ack`.

## Operation
- FSM states: `ASSERT`, `SETTLE`, `READY`. Reset state is `ASSERT` with counter = `RST_CYCLES`-1.
- `ASSERT`:
  - `phy_rstn`=0, `phy_ready`=0.
  - Counter decrements each cycle; at 0 → `SETTLE`, counter loads `SETTLE_CYCLES`-1.
- `SETTLE`:
  - `phy_rstn`=1, `phy_ready`=0.
  - Counter decrements; at 0 → `READY`.
- `READY`: `phy_rstn`=1, `phy_ready`=1. Holds indefinitely.
- `sw_rst_req` in any state → `ASSERT` with the counter reloaded to `RST_CYCLES`-1. In `ASSERT` this restarts the full hold.
- Interrupt path:
  - `phy_int_n` is synchronised through 2 flops, then a falling-edge detect produces an event.
  - Events are counted only in `READY`. Events in `ASSERT`/`SETTLE` are discarded; the PHY drives the pin undefined while in reset.
  - On an event, `irq_pend` is set to 1 and `irq_cnt` increments, saturating at 255.
  - `irq_ack` clears `irq_pend` and zeroes `irq_cnt`.
  - If `irq_ack` and an event occur in the same cycle, the event wins: `irq_pend`=1, `irq_cnt`=1.
  - A level held low produces exactly one event.
- Entering `ASSERT` (by `sw_rst_req`) clears `irq_pend` and `irq_cnt`.
- All outputs are registered. Reset values: `phy_rstn`=0, `phy_ready`=0, `irq_pend`=0, `irq_cnt`=0. Synchroniser flops reset to 1.

## Timing
- After `rstn` deasserts, `phy_rstn` stays 0 for exactly `RST_CYCLES` rising edges and is 1 after edge `RST_CYCLES`+1.
- `phy_ready` rises exactly `SETTLE_CYCLES` edges after `phy_rstn` rises.
- `sw_rst_req` sampled at edge N gives `phy_rstn`=0 and `phy_ready`=0 after edge N.
- `phy_int_n` falling to `irq_pend`/`irq_cnt` update: 3 clocks (2 sync + 1 register).
- `irq_ack` at edge N gives `irq_pend`=0 after edge N.
- Minimum separable event spacing: `phy_int_n` must be high for ≥ 2 clocks between events.
- Asserting `rstn` mid-sequence forces the reset values immediately, with no clock required.

## Configuration
- `PHY_RST_IRQ_EN` defined:
  - Synchroniser, edge detect, `irq_pend` and `irq_cnt` logic are present, as described above.
- `PHY_RST_IRQ_EN` undefined:
  - Interrupt logic is removed; `phy_int_n` and `irq_ack` are ignored.
  - `irq_pend` is tied to 0 and `irq_cnt` to 0.
  - The reset FSM is unchanged.

## Structure
- Shared package `onets_pkg`: FSM state encoding `phy_rst_state_t` (`ASSERT`=2'd0, `SETTLE`=2'd1, `READY`=2'd2) and constant `PHY_IRQ_CNT_MAX`=8'd255.
- One sub-module, `sync_2ff`: a generic 2-flop synchroniser with a reset value parameter, reused for the interrupt pin.
- Counter and FSM live in `phy_rst_seq` itself.

## Test plan
All scenarios use `RST_CYCLES`=16, `SETTLE_CYCLES`=8, `PHY_RST_IRQ_EN` defined.
- Release `rstn` → `phy_rstn` low for 16 edges and high from edge 17; `phy_ready` high 8 edges later; `irq` outputs stay 0.
- `sw_rst_req` pulse in `READY`, then a second pulse 5 cycles into `ASSERT` → `phy_ready` drops next edge; `phy_rstn` low for 21 total edges; `irq_cnt` cleared.
- Three `phy_int_n` low pulses (4 cycles low, 4 high) in `READY` → `irq_pend`=1 and `irq_cnt`=3, each update 3 clocks after the falling edge.
- 300 interrupt pulses without ack → `irq_cnt` saturates at 255; `irq_ack` → `irq_cnt`=0, `irq_pend`=0.
- `irq_ack` coincident with a synchronised edge → `irq_pend`=1, `irq_cnt`=1.
- `phy_int_n` toggling during `ASSERT`/`SETTLE`, and `rstn` asserted mid-`SETTLE` → no events counted; all outputs at reset values immediately.
